// File: rtl/disp_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl_if
//   Bundles the result-side signals and the display-side pins of the scan
//   controller into one connection.
//
//   Signals:
//     sumtotal  [7:0]  unsigned magnitude to display (datapath -> controller)
//     done             result valid level; its rising edge requests a capture
//     negative         sign of sumtotal, sampled together with it
//     seg       [6:0]  segments {g,f,e,d,c,b,a}, active-low
//     an        [3:0]  digit enables, active-low (0=units .. 3=sign)
//     busy             conversion in progress
//     valid            at least one conversion completed since reset
//     state_dbg [1:0]  current conversion FSM state, for observation only
//
//   Modports:
//     master  - the side that supplies results and watches the display
//     slave   - the scan controller itself
// -----------------------------------------------------------------------------
interface disp_scan_ctrl_if;
    logic [7:0] sumtotal;
    logic       done;
    logic       negative;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    logic       valid;
    logic [1:0] state_dbg;

    modport master (
        output sumtotal, done, negative,
        input  seg, an, busy, valid, state_dbg
    );

    modport slave (
        input  sumtotal, done, negative,
        output seg, an, busy, valid, state_dbg
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
//   Captures an 8-bit result and its sign on each accepted rising edge of
//   `done`, converts the magnitude to three BCD digits with an iterative
//   shift-add-3 sequence, and time-multiplexes units / tens / hundreds / sign
//   over a shared active-low 7-segment bus.
//
//   Ports:
//     clk    - system clock, rising edge
//     rst_n  - asynchronous active-low reset
//     bus    - disp_scan_ctrl_if.slave (sumtotal, done, negative in;
//              seg, an, busy, valid, state_dbg out)
//
//   Parameters:
//     REFRESH_DIV - clock cycles each digit is shown (>= 1)
//
//   Handshake: `done` is a level; only its 0->1 transition while the
//   controller is idle starts a conversion, and sumtotal/negative are taken
//   on that same edge only. `busy` is high from the edge after the accepted
//   start until the display registers are loaded; `valid` rises together with
//   the first loaded value and stays high until reset. Rising edges of `done`
//   seen while busy are dropped, not queued.
// -----------------------------------------------------------------------------
module disp_scan_ctrl #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    disp_scan_ctrl_if.slave   bus
);

    // ---------------------------------------------------------------------
    // Constants
    // ---------------------------------------------------------------------
    localparam int             RW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0]  RMAX      = RW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_BLANK = 7'h7F;
    localparam logic [6:0]     SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t          state, state_n;
    logic            done_q;
    logic [7:0]      shreg, shreg_n;
    logic [11:0]     bcd, bcd_n;
    logic [2:0]      cnt, cnt_n;
    logic            neg_cap, neg_cap_n;
    logic            load_disp;

    logic [3:0]      d_u, d_t, d_h;
    logic            d_neg;
    logic            valid_r;

    logic [RW-1:0]   rcnt;
    logic [1:0]      idx;

    logic            start;
    logic [11:0]     bcd_adj;
    logic [6:0]      cur_seg;

    // ---------------------------------------------------------------------
    // Helpers
    // ---------------------------------------------------------------------
    // Double-dabble correction: any BCD nibble >= 5 gets +3 so the following
    // left shift carries correctly into the next decade.
    function automatic logic [11:0] add3(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------------
    // Start detection
    // ---------------------------------------------------------------------
    assign start = bus.done & ~done_q & (state == IDLE);

    // ---------------------------------------------------------------------
    // Conversion FSM: state and working registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            shreg   <= '0;
            bcd     <= '0;
            cnt     <= '0;
            neg_cap <= 1'b0;
        end else begin
            state   <= state_n;
            done_q  <= bus.done;
            shreg   <= shreg_n;
            bcd     <= bcd_n;
            cnt     <= cnt_n;
            neg_cap <= neg_cap_n;
        end
    end

    // ---------------------------------------------------------------------
    // Conversion FSM: next state and working-register updates
    // ---------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bcd_n     = bcd;
        cnt_n     = cnt;
        neg_cap_n = neg_cap;
        load_disp = 1'b0;
        bcd_adj   = add3(bcd);

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_n   = bus.sumtotal;
                    neg_cap_n = bus.negative;
                    bcd_n     = '0;
                    cnt_n     = '0;
                    state_n   = CONV;
                end
            end

            CONV: begin
                // Correct, then shift {bcd,shreg} left by one as a 20-bit word.
                {bcd_n, shreg_n} = {bcd_adj[10:0], shreg, 1'b0};
                cnt_n            = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_n = UPDATE;
                end
            end

            UPDATE: begin
                load_disp = 1'b1;
                state_n   = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Display registers: only written in UPDATE, so the scan keeps showing
    // the previous value for the whole conversion.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_u     <= '0;
            d_t     <= '0;
            d_h     <= '0;
            d_neg   <= 1'b0;
            valid_r <= 1'b0;
        end else if (load_disp) begin
            d_u     <= bcd[3:0];
            d_t     <= bcd[7:4];
            d_h     <= bcd[11:8];
            d_neg   <= neg_cap;
            valid_r <= 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Scan timer: free-running, independent of the conversion FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == RMAX) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + RW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Digit content. Blank digits keep their anode asserted and drive 7F.
    // Tens are only suppressed when hundreds are also zero, so 105 shows "0".
    // ---------------------------------------------------------------------
    always_comb begin
        cur_seg = SEG_BLANK;
        case (idx)
            2'd0: cur_seg = seg_of(d_u);
            2'd1: if ((d_h != 4'd0) || (d_t != 4'd0)) cur_seg = seg_of(d_t);
            2'd2: if (d_h != 4'd0) cur_seg = seg_of(d_h);
            2'd3: if (d_neg) cur_seg = SEG_DASH;
            default: cur_seg = SEG_BLANK;
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs: driven from registered idx / digit registers so seg and an
    // change on the same edge as idx.
    // ---------------------------------------------------------------------
    assign bus.seg       = valid_r ? cur_seg : SEG_BLANK;
    assign bus.an        = valid_r ? ~(4'b0001 << idx) : 4'b1111;
    assign bus.busy      = (state != IDLE);
    assign bus.valid     = valid_r;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_ctrl
//   Drives two controllers (REFRESH_DIV=4 and REFRESH_DIV=1) with the same
//   result stream and compares seg/an/busy/valid every cycle against a
//   reference model that works on whole numbers: captured value, capture
//   edge number and edges elapsed since reset.
// -----------------------------------------------------------------------------
module tb_disp_scan_ctrl;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    disp_scan_ctrl_if bus4 ();
    disp_scan_ctrl_if bus1 ();

    assign bus1.sumtotal = bus4.sumtotal;
    assign bus1.done     = bus4.done;
    assign bus1.negative = bus4.negative;

    disp_scan_ctrl #(.REFRESH_DIV(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    disp_scan_ctrl #(.REFRESH_DIV(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // ---------------------------------------------------------------------
    // Scoreboard counters and the checking task
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    //   k          : rising edges since reset release
    //   a capture at edge N shows up at edge N+9; busy covers N..N+8
    // ---------------------------------------------------------------------
    int   k;
    logic m_done_q;
    logic m_pend;
    int   m_start;
    int   m_pend_val;
    logic m_pend_neg;
    int   m_val;
    logic m_neg;
    logic m_valid;

    task automatic model_reset();
        k          = 0;
        m_done_q   = 1'b0;
        m_pend     = 1'b0;
        m_start    = 0;
        m_pend_val = 0;
        m_pend_neg = 1'b0;
        m_val      = 0;
        m_neg      = 1'b0;
        m_valid    = 1'b0;
    endtask

    task automatic model_step();
        logic idle_now;
        k++;
        idle_now = !m_pend;
        if (m_pend && (k == m_start + 9)) begin
            m_val   = m_pend_val;
            m_neg   = m_pend_neg;
            m_valid = 1'b1;
            m_pend  = 1'b0;
        end
        if (idle_now && bus4.done && !m_done_q) begin
            m_pend     = 1'b1;
            m_start    = k;
            m_pend_val = int'(bus4.sumtotal);
            m_pend_neg = bus4.negative;
        end
        m_done_q = bus4.done;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    function automatic logic [6:0] seg_code(input int d);
        logic [6:0] s;
        case (d)
            0:       s = 7'h40;
            1:       s = 7'h79;
            2:       s = 7'h24;
            3:       s = 7'h30;
            4:       s = 7'h19;
            5:       s = 7'h12;
            6:       s = 7'h02;
            7:       s = 7'h78;
            8:       s = 7'h00;
            9:       s = 7'h10;
            10:      s = 7'h3F;   // minus sign
            default: s = 7'h7F;   // blank
        endcase
        return s;
    endfunction

    task automatic expected(input int div, output logic [3:0] an_e, output logic [6:0] seg_e);
        int pos;
        int dig;
        if (!m_valid) begin
            an_e  = 4'b1111;
            seg_e = 7'h7F;
        end else begin
            pos = (k / div) % 4;
            case (pos)
                0:       dig = m_val % 10;
                1:       dig = (m_val < 10)  ? 11 : (m_val / 10) % 10;
                2:       dig = (m_val < 100) ? 11 : m_val / 100;
                default: dig = m_neg ? 10 : 11;
            endcase
            an_e  = 4'b1111;
            an_e[pos] = 1'b0;
            seg_e = seg_code(dig);
        end
    endtask

    task automatic check_all();
        logic [3:0] an_e;
        logic [6:0] seg_e;
        expected(4, an_e, seg_e);
        check("an_div4",    32'(bus4.an),    32'(an_e));
        check("seg_div4",   32'(bus4.seg),   32'(seg_e));
        check("busy_div4",  32'(bus4.busy),  32'(m_pend));
        check("valid_div4", 32'(bus4.valid), 32'(m_valid));
        expected(1, an_e, seg_e);
        check("an_div1",    32'(bus1.an),    32'(an_e));
        check("seg_div1",   32'(bus1.seg),   32'(seg_e));
        check("busy_div1",  32'(bus1.busy),  32'(m_pend));
        check("valid_div1", 32'(bus1.valid), 32'(m_valid));
    endtask

    // Every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check_all();
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks (inputs change on the falling edge)
    // ---------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic convert(input logic [7:0] v, input logic ng, input int hold, input int gap);
        bus4.sumtotal = v;
        bus4.negative = ng;
        bus4.done     = 1'b1;
        cyc(hold);
        bus4.done     = 1'b0;
        cyc(gap);
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        rst_n         = 1'b0;
        bus4.sumtotal = 8'd0;
        bus4.done     = 1'b0;
        bus4.negative = 1'b0;

        cyc(3);
        #2 rst_n = 1'b1;
        cyc(100);                          // idle after reset: nothing lights

        // Directed values from the display rules.
        convert(8'd255, 1'b0, 1, 30);
        convert(8'd7,   1'b1, 1, 30);
        convert(8'd105, 1'b0, 1, 30);
        convert(8'd0,   1'b0, 1, 30);
        convert(8'd10,  1'b1, 2, 30);
        convert(8'd100, 1'b0, 1, 30);

        // done held high for 50 cycles while sumtotal wanders: one capture.
        bus4.sumtotal = 8'd123;
        bus4.negative = 1'b1;
        bus4.done     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            bus4.sumtotal = 8'($urandom_range(0, 255));
            bus4.negative = 1'($urandom_range(0, 1));
        end
        bus4.done = 1'b0;
        cyc(30);

        // Second rising edge at N+3 while converting is dropped.
        bus4.sumtotal = 8'd42;
        bus4.negative = 1'b0;
        bus4.done     = 1'b1;
        cyc(1);
        bus4.done     = 1'b0;
        cyc(2);
        bus4.sumtotal = 8'd99;
        bus4.negative = 1'b1;
        bus4.done     = 1'b1;
        cyc(2);
        bus4.done     = 1'b0;
        cyc(30);

        // Reset in the middle of a conversion.
        bus4.sumtotal = 8'd200;
        bus4.done     = 1'b1;
        cyc(5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_an",    32'(bus4.an),    32'h0000_000F);
        check("rst_seg",   32'(bus4.seg),   32'h0000_007F);
        check("rst_busy",  32'(bus4.busy),  32'd0);
        check("rst_valid", 32'(bus4.valid), 32'd0);
        bus4.done = 1'b0;
        cyc(2);
        #2 rst_n = 1'b1;
        cyc(30);                           // valid must stay low with no new edge

        // Randomized traffic, including edges that land while busy.
        for (int i = 0; i < 30; i++) begin
            convert(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 4)), int'($urandom_range(3, 40)));
        end
        cyc(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
